axi4_wr_arbiter: RTL and testbench
==================================

# axi4_wr_arbiter

Round-robin arbiter that shares one AXI4 write port (AW/W/B channels) among NUM_M requesters. It allows one transaction in flight at a time. A requester's grant is held from AW acceptance through the final W beat and the B response; then the grant passes to the next requester in round-robin order. The block sits between several DMA/stream write engines and a single AXI4 memory or interconnect slave port.

## Interface
Parameters:
- NUM_M, 4: number of requesters, 2..16.
- ID_W, 4: master-side ID width; must be ≥ clog2(NUM_M).
- ADDR_W, 32: address width.
- DATA_W, 32: data width, a multiple of 8.

Ports (requester-side vectors are packed; requester i occupies slice i):
- ACLK  in  1  clock.
- ARESETn  in  1  reset, synchronous, active-low.
- s_awvalid / s_awready  in/out  NUM_M each  per-requester AW handshake.
- s_awaddr  in  NUM_M*ADDR_W  burst address.
- s_awlen  in  NUM_M*8  beats minus 1.
- s_awsize  in  NUM_M*3  beat size.
- s_awburst  in  NUM_M*2  burst type.
- s_wvalid / s_wready  in/out  NUM_M each  per-requester W handshake.
- s_wdata  in  NUM_M*DATA_W  write data.
- s_wstrb  in  NUM_M*DATA_W/8  byte strobes.
- s_wlast  in  NUM_M  last beat of burst.
- s_bvalid / s_bready  out/in  NUM_M each  per-requester B handshake.
- s_bresp  out  NUM_M*2  write response, broadcast.
- m_awid  out  ID_W  zero-extended granted index.
- m_awvalid / m_awready  out/in  1 each  AW handshake.
- m_awaddr, m_awlen, m_awsize, m_awburst  out  ADDR_W/8/3/2  muxed from the granted requester.
- m_awlock, m_awcache, m_awprot, m_awqos, m_awregion  out  1/4/3/4/4  constants 0, 4'b0011, 0, 0, 0.
- m_wvalid / m_wready  out/in  1 each  W handshake.
- m_wdata, m_wstrb, m_wlast  out  DATA_W/(DATA_W/8)/1  muxed W payload.
- m_bid  in  ID_W  ignored.
- m_bvalid / m_bready  in/out  1 each  B handshake.
- m_bresp  in  2  write response.
- grant  out  clog2(NUM_M)  current or last granted index.
- busy  out  1  high in every state except IDLE.

## Operation
- Registers: state, grant, and last (the previous winner).
- States and transitions:
  - IDLE: if any s_awvalid is high, select the first set bit scanning last+1, last+2, … modulo NUM_M. Register it as grant and go to ADDR. If none are set, stay in IDLE.
  - ADDR: m_awvalid = s_awvalid[grant]; s_awready[grant] = m_awready. On the m_aw handshake, go to DATA.
  - DATA: m_wvalid = s_wvalid[grant]; s_wready[grant] = m_wready. On a W handshake with s_wlast[grant]=1, go to RESP.
  - RESP: s_bvalid[grant] = m_bvalid; m_bready = s_bready[grant]. On the B handshake, set last <= grant and go to IDLE.
- Every channel not active in the current state, and every non-granted requester, sees valid and ready driven 0.
- The m_aw* and m_w* payloads are muxed by grant in all states. Payload value is a don't-care when the corresponding valid is 0.
- A requester asserting W before its AW is accepted is legal; its W is not accepted until DATA.
- The arbiter does not count beats; WLAST is taken from the requester. A missing WLAST hangs the port. This is a requester error.
- After grant is registered, requests from other requesters, and the granted requester dropping s_awvalid, do not change grant.
- Reset: state=IDLE, grant=0, last=NUM_M-1, so requester 0 has first priority.

## Timing
- Reset values of all outputs: m_awvalid, m_wvalid, m_bready, s_awready, s_wready, s_bvalid = 0; busy=0; grant=0; m_awid=0.
- Reset asserted mid-transaction returns the block to IDLE on the next edge. All valids and readies are 0 from that cycle on; the in-flight burst is abandoned.
- Arbitration latency: s_awvalid rises in cycle T while in IDLE; state=ADDR and m_awvalid=1 in T+1.
- Handshake signals are pure pass-through (combinational) through the grant mux. There is no combinational path from any m_*ready to m_*valid.
- Minimum transaction occupancy is 1 (IDLE) + 1 (ADDR) + (AWLEN+1) (DATA) + 1 (RESP) cycles. There is no overlap between transactions.
- Round-robin fairness: with all requesters continuously requesting, each is granted exactly once per NUM_M transactions.

## Test plan
- Single requester 0, AWLEN=3, addr 0x1000, all readies high: m_awvalid in T+1, m_awid=0, 4 W beats with WLAST on the 4th, B OKAY forwarded only to s_bvalid[0]; back to IDLE, busy=0.
- Requesters 1 and 2 asserting simultaneously after reset, three transactions each: grant order 1,2,1,2,1,2. m_awaddr and m_awid match the winner each time.
- m_awready held low for 5 cycles in ADDR: m_awvalid stays 1 with stable payload. s_awready[grant]=0 until m_awready=1; no state advance.
- Requester 3 asserts s_wvalid 2 cycles before its AW is accepted: s_wready[3]=0 until DATA, then all beats pass in order. m_bresp=2'b10 (SLVERR) appears on s_bresp with s_bvalid[3]=1.
- ARESETn pulsed low during beat 2 of an AWLEN=7 burst: the next cycle has busy=0, all valids and readies 0, last=NUM_M-1. A fresh request from requester 0 is then granted normally.
- s_bready[grant] held low for 4 cycles in RESP: m_bready=0 and the state holds. A pending AW from another requester is not accepted until after the B handshake.

Source files
------------

// File: rtl/axi4_wr_arbiter_if.sv
// Signal bundle for the shared AXI4 write port.
//   s_* : packed per-requester vectors, requester i occupies slice i.
//   m_* : the single downstream AXI4 write port (AW/W/B).
// Modports:
//   master : the arbiter's view. It is the AXI master toward memory and the
//            slave toward each requester.
//   slave  : the environment's view (requesters plus downstream memory).
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where valid and ready are both 1. Valid never depends on ready, and payload
// must be held stable while valid is high and ready is low.
interface axi4_wr_arbiter_if #(
  parameter int NUM_M  = 4,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester side
  logic [NUM_M-1:0]            s_awvalid;
  logic [NUM_M-1:0]            s_awready;
  logic [NUM_M*ADDR_W-1:0]     s_awaddr;
  logic [NUM_M*8-1:0]          s_awlen;
  logic [NUM_M*3-1:0]          s_awsize;
  logic [NUM_M*2-1:0]          s_awburst;
  logic [NUM_M-1:0]            s_wvalid;
  logic [NUM_M-1:0]            s_wready;
  logic [NUM_M*DATA_W-1:0]     s_wdata;
  logic [NUM_M*DATA_W/8-1:0]   s_wstrb;
  logic [NUM_M-1:0]            s_wlast;
  logic [NUM_M-1:0]            s_bvalid;
  logic [NUM_M-1:0]            s_bready;
  logic [NUM_M*2-1:0]          s_bresp;
  // downstream side
  logic [ID_W-1:0]             m_awid;
  logic                        m_awvalid;
  logic                        m_awready;
  logic [ADDR_W-1:0]           m_awaddr;
  logic [7:0]                  m_awlen;
  logic [2:0]                  m_awsize;
  logic [1:0]                  m_awburst;
  logic                        m_awlock;
  logic [3:0]                  m_awcache;
  logic [2:0]                  m_awprot;
  logic [3:0]                  m_awqos;
  logic [3:0]                  m_awregion;
  logic                        m_wvalid;
  logic                        m_wready;
  logic [DATA_W-1:0]           m_wdata;
  logic [DATA_W/8-1:0]         m_wstrb;
  logic                        m_wlast;
  logic [ID_W-1:0]             m_bid;
  logic                        m_bvalid;
  logic                        m_bready;
  logic [1:0]                  m_bresp;

  modport master (
    input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
    input  s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    output s_awready, s_wready, s_bvalid, s_bresp,
    input  m_awready, m_wready, m_bid, m_bvalid, m_bresp,
    output m_awid, m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
    output m_awlock, m_awcache, m_awprot, m_awqos, m_awregion,
    output m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
  );

  modport slave (
    output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst,
    output s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bresp,
    output m_awready, m_wready, m_bid, m_bvalid, m_bresp,
    input  m_awid, m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
    input  m_awlock, m_awcache, m_awprot, m_awqos, m_awregion,
    input  m_wvalid, m_wdata, m_wstrb, m_wlast, m_bready
  );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter sharing one AXI4 write port among NUM_M requesters,
// one transaction in flight at a time. The grant is held from AW acceptance
// through the last W beat and the B response, then passes on.
// Ports:
//   ACLK, ARESETn : clock, synchronous active-low reset
//   bus           : axi4_wr_arbiter_if.master (requester vectors + m_* port)
//   grant         : current (or most recent) granted requester index
//   busy          : 1 in every state except IDLE
//   dbg_state_o   : FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 RESP)
//   dbg_last_o    : previous winner, the round-robin pointer
module axi4_wr_arbiter #(
  parameter int NUM_M  = 4,
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int GW    = $clog2(NUM_M),
  localparam int SW    = DATA_W / 8
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  axi4_wr_arbiter_if.master bus,
  output logic [GW-1:0] grant,
  output logic          busy,
  output logic [1:0]    dbg_state_o,
  output logic [GW-1:0] dbg_last_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] last_q;
  logic          busy_q;

  logic [GW-1:0] grant_d;
  logic          req_any;

  // Round-robin pick: first requesting index scanning last+1, last+2, ...
  // wrapping modulo NUM_M, so the previous winner is checked last.
  always_comb begin
    int idx;
    grant_d = '0;
    req_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      idx = (int'(last_q) + k) % NUM_M;
      if (!req_any && bus.s_awvalid[idx]) begin
        req_any = 1'b1;
        grant_d = GW'(idx);
      end
    end
  end

  // Handshake routing: only the channel owned by the current state is
  // connected, and only for the granted requester. Valids come from the
  // requester/memory side only, never from a ready.
  always_comb begin
    bus.s_awready = '0;
    bus.s_wready  = '0;
    bus.s_bvalid  = '0;
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.m_bready  = 1'b0;
    case (state_q)
      S_ADDR: begin
        bus.m_awvalid          = bus.s_awvalid[grant_q];
        bus.s_awready[grant_q] = bus.m_awready;
      end
      S_DATA: begin
        bus.m_wvalid          = bus.s_wvalid[grant_q];
        bus.s_wready[grant_q] = bus.m_wready;
      end
      S_RESP: begin
        bus.s_bvalid[grant_q] = bus.m_bvalid;
        bus.m_bready          = bus.s_bready[grant_q];
      end
      default: ;
    endcase
  end

  // Payload muxes follow grant in every state; only meaningful under valid.
  assign bus.m_awaddr  = bus.s_awaddr [grant_q*ADDR_W +: ADDR_W];
  assign bus.m_awlen   = bus.s_awlen  [grant_q*8      +: 8];
  assign bus.m_awsize  = bus.s_awsize [grant_q*3      +: 3];
  assign bus.m_awburst = bus.s_awburst[grant_q*2      +: 2];
  assign bus.m_wdata   = bus.s_wdata  [grant_q*DATA_W +: DATA_W];
  assign bus.m_wstrb   = bus.s_wstrb  [grant_q*SW     +: SW];
  assign bus.m_wlast   = bus.s_wlast  [grant_q];

  // Fixed AW attributes: normal access, bufferable + modifiable.
  assign bus.m_awlock   = 1'b0;
  assign bus.m_awcache  = 4'b0011;
  assign bus.m_awprot   = 3'b000;
  assign bus.m_awqos    = 4'b0000;
  assign bus.m_awregion = 4'b0000;

  // The ID carries the granted index, zero-extended.
  always_comb begin
    bus.m_awid          = '0;
    bus.m_awid[GW-1:0]  = grant_q;
  end

  // Responses carry no routing information beyond grant; the response code
  // is broadcast and qualified per requester by s_bvalid.
  assign bus.s_bresp = {NUM_M{bus.m_bresp}};

  // m_bid is not needed: only one transaction is ever outstanding.
  logic unused_ok;
  assign unused_ok = ^bus.m_bid;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_M - 1);
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            grant_q <= grant_d;
            state_q <= S_ADDR;
            busy_q  <= 1'b1;
          end
        end
        S_ADDR: begin
          if (bus.m_awvalid && bus.m_awready) state_q <= S_DATA;
        end
        S_DATA: begin
          // Beats are not counted; the requester's WLAST ends the burst.
          if (bus.m_wvalid && bus.m_wready && bus.s_wlast[grant_q])
            state_q <= S_RESP;
        end
        S_RESP: begin
          if (bus.m_bvalid && bus.m_bready) begin
            last_q  <= grant_q;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;
  assign dbg_last_o  = last_q;

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
module tb_axi4_wr_arbiter;
  localparam int NUM_M  = 4;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int GW     = 2;
  localparam int SW     = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // ---------------- clock / reset ----------------
  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic [GW-1:0] grant;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [GW-1:0] dbg_last;

  always #5 ACLK = ~ACLK;

  axi4_wr_arbiter_if #(.NUM_M(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W),
                       .DATA_W(DATA_W)) bus ();

  axi4_wr_arbiter #(.NUM_M(NUM_M), .ID_W(ID_W), .ADDR_W(ADDR_W),
                    .DATA_W(DATA_W)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .bus         (bus),
    .grant       (grant),
    .busy        (busy),
    .dbg_state_o (dbg_state),
    .dbg_last_o  (dbg_last)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [GW-1:0] exp_q[$];
  int cnt[NUM_M];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [NUM_M-1:0] onehot(input int i);
    logic [NUM_M-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return oh;
  endfunction

  task automatic drive_idle();
    bus.s_awvalid = '0;
    bus.s_awaddr  = '0;
    bus.s_awlen   = '0;
    bus.s_awsize  = '0;
    bus.s_awburst = '0;
    bus.s_wvalid  = '0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wlast   = '0;
    bus.s_bready  = '1;
    bus.m_awready = 1'b1;
    bus.m_wready  = 1'b1;
    bus.m_bid     = '0;
    bus.m_bvalid  = 1'b0;
    bus.m_bresp   = 2'b00;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},    busy,          1'b0);
    chk({tag, "_state"},   dbg_state,     ST_IDLE);
    chk({tag, "_awvalid"}, bus.m_awvalid, 1'b0);
    chk({tag, "_wvalid"},  bus.m_wvalid,  1'b0);
    chk({tag, "_bready"},  bus.m_bready,  1'b0);
    chk({tag, "_awready"}, bus.s_awready, 4'b0000);
    chk({tag, "_wready"},  bus.s_wready,  4'b0000);
    chk({tag, "_bvalid"},  bus.s_bvalid,  4'b0000);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    drive_idle();
    tick();
    tick();
    ARESETn = 1'b1;
    settle();
    chk_quiet("rst");
    chk("rst_grant", grant, 2'd0);
    chk("rst_awid", bus.m_awid, 4'd0);
    chk("rst_last", dbg_last, 2'd3);
  endtask

  task automatic req_aw(input int i, input logic [31:0] addr, input logic [7:0] len);
    bus.s_awaddr[i*ADDR_W +: ADDR_W] = addr;
    bus.s_awlen[i*8 +: 8]            = len;
    bus.s_awsize[i*3 +: 3]           = 3'd2;
    bus.s_awburst[i*2 +: 2]          = 2'b01;
    bus.s_awvalid[i]                 = 1'b1;
  endtask

  // Called in the first ADDR cycle with m_awready=1; leaves the DUT in DATA.
  task automatic addr_phase(input int i, input logic [31:0] addr, input logic [7:0] len,
                            input bit keep);
    settle();
    chk("aw_state",   dbg_state,     ST_ADDR);
    chk("aw_grant",   grant,         i);
    chk("aw_busy",    busy,          1'b1);
    chk("aw_valid",   bus.m_awvalid, 1'b1);
    chk("aw_id",      bus.m_awid,    i);
    chk("aw_addr",    bus.m_awaddr,  addr);
    chk("aw_len",     bus.m_awlen,   len);
    chk("aw_cache",   bus.m_awcache, 4'b0011);
    chk("aw_ready_s", bus.s_awready, onehot(i));
    chk("aw_wready",  bus.s_wready,  4'b0000);
    tick();
    if (!keep) bus.s_awvalid[i] = 1'b0;
  endtask

  // Drives n beats starting at beat 0; WLAST on beat index last_idx.
  task automatic data_phase(input int i, input int n, input int last_idx);
    logic [31:0] d;
    logic [3:0]  s;
    for (int k = 0; k < n; k++) begin
      d = 32'hA000_0000 + i * 256 + k;
      s = k[0] ? 4'h3 : 4'hF;
      bus.s_wdata[i*DATA_W +: DATA_W] = d;
      bus.s_wstrb[i*SW +: SW]         = s;
      bus.s_wlast[i]                  = (k == last_idx);
      bus.s_wvalid[i]                 = 1'b1;
      settle();
      chk("w_state",   dbg_state,    ST_DATA);
      chk("w_valid",   bus.m_wvalid, 1'b1);
      chk("w_data",    bus.m_wdata,  d);
      chk("w_strb",    bus.m_wstrb,  s);
      chk("w_last",    bus.m_wlast,  (k == last_idx));
      chk("w_ready_s", bus.s_wready, onehot(i));
      tick();
    end
    bus.s_wvalid[i] = 1'b0;
    bus.s_wlast[i]  = 1'b0;
  endtask

  task automatic resp_phase(input int i, input logic [1:0] resp);
    bus.m_bvalid = 1'b1;
    bus.m_bresp  = resp;
    settle();
    chk("b_state",   dbg_state,    ST_RESP);
    chk("b_valid_s", bus.s_bvalid, onehot(i));
    chk("b_resp_s",  bus.s_bresp,  {NUM_M{resp}});
    chk("b_ready_m", bus.m_bready, 1'b1);
    chk("b_wvalid",  bus.m_wvalid, 1'b0);
    tick();
    bus.m_bvalid = 1'b0;
    settle();
    chk("b_done_busy",  busy,      1'b0);
    chk("b_done_state", dbg_state, ST_IDLE);
    chk("b_done_last",  dbg_last,  i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [GW-1:0] g;
    ARESETn = 1'b0;
    drive_idle();

    // Single requester 0, 4-beat burst.
    do_reset();
    req_aw(0, 32'h0000_1000, 8'd3);
    settle();
    chk("t1_idle_awvalid", bus.m_awvalid, 1'b0);
    tick();
    addr_phase(0, 32'h0000_1000, 8'd3, 1'b0);
    data_phase(0, 4, 3);
    resp_phase(0, 2'b00);

    // Requesters 1 and 2 competing: grant alternates 1,2,1,2,1,2.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
    end
    for (int j = 0; j < NUM_M; j++) cnt[j] = 0;
    req_aw(1, 32'h0000_2100, 8'd1);
    req_aw(2, 32'h0000_2200, 8'd1);
    for (int t = 0; t < 6; t++) begin
      tick();
      g = exp_q.pop_front();
      cnt[g]++;
      addr_phase(g, 32'h0000_2000 + g * 32'h100, 8'd1, cnt[g] < 3);
      data_phase(g, 2, 1);
      resp_phase(g, 2'b00);
    end
    chk("t2_queue_empty", exp_q.size(), 0);

    // m_awready low for 5 cycles in ADDR (last=2, so requester 0 wins).
    bus.m_awready = 1'b0;
    req_aw(0, 32'h0000_3000, 8'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t3_state",   dbg_state,     ST_ADDR);
      chk("t3_awvalid", bus.m_awvalid, 1'b1);
      chk("t3_awaddr",  bus.m_awaddr,  32'h0000_3000);
      chk("t3_awready", bus.s_awready, 4'b0000);
      tick();
    end
    bus.m_awready = 1'b1;
    addr_phase(0, 32'h0000_3000, 8'd0, 1'b0);
    data_phase(0, 1, 0);
    resp_phase(0, 2'b00);

    // s_bready low for 4 cycles in RESP with requester 2 pending.
    req_aw(1, 32'h0000_6000, 8'd0);
    tick();
    req_aw(2, 32'h0000_6100, 8'd0);
    addr_phase(1, 32'h0000_6000, 8'd0, 1'b0);
    data_phase(1, 1, 0);
    bus.s_bready[1] = 1'b0;
    bus.m_bvalid    = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t6_state",   dbg_state,     ST_RESP);
      chk("t6_bready",  bus.m_bready,  1'b0);
      chk("t6_bvalid",  bus.s_bvalid,  4'b0010);
      chk("t6_awready", bus.s_awready, 4'b0000);
      chk("t6_awvalid", bus.m_awvalid, 1'b0);
      tick();
    end
    bus.s_bready[1] = 1'b1;
    resp_phase(1, 2'b00);
    tick();
    addr_phase(2, 32'h0000_6100, 8'd0, 1'b0);
    data_phase(2, 1, 0);
    resp_phase(2, 2'b00);

    // Requester 3 raises W two cycles before its AW is accepted; SLVERR.
    req_aw(3, 32'h0000_4000, 8'd2);
    bus.s_wdata[3*DATA_W +: DATA_W] = 32'hA000_0300;
    bus.s_wstrb[3*SW +: SW]         = 4'hF;
    bus.s_wvalid[3]                 = 1'b1;
    bus.m_awready                   = 1'b0;
    settle();
    chk("t4_idle_wready", bus.s_wready, 4'b0000);
    chk("t4_idle_wvalid", bus.m_wvalid, 1'b0);
    tick();
    settle();
    chk("t4_addr_grant",  grant,        2'd3);
    chk("t4_addr_wready", bus.s_wready, 4'b0000);
    chk("t4_addr_wvalid", bus.m_wvalid, 1'b0);
    tick();
    bus.m_awready = 1'b1;
    addr_phase(3, 32'h0000_4000, 8'd2, 1'b0);
    data_phase(3, 3, 2);
    resp_phase(3, 2'b10);

    // Reset during beat 2 of an 8-beat burst from requester 0.
    req_aw(0, 32'h0000_5000, 8'd7);
    tick();
    addr_phase(0, 32'h0000_5000, 8'd7, 1'b0);
    data_phase(0, 2, 7);
    bus.s_wdata[0 +: DATA_W] = 32'hA000_0002;
    bus.s_wvalid[0]          = 1'b1;
    ARESETn                  = 1'b0;
    tick();
    settle();
    chk_quiet("t5_rst");
    chk("t5_last",  dbg_last, 2'd3);
    chk("t5_grant", grant,    2'd0);
    ARESETn         = 1'b1;
    bus.s_wvalid[0] = 1'b0;
    req_aw(0, 32'h0000_5100, 8'd0);
    tick();
    addr_phase(0, 32'h0000_5100, 8'd0, 1'b0);
    data_phase(0, 1, 0);
    resp_phase(0, 2'b00);

    // No requests: stays idle.
    tick();
    tick();
    settle();
    chk_quiet("t7_idle");

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
